// File: rtl/blit_pixel_writer_if.sv
// Bus interfaces for blit_pixel_writer: the pixel stream from the line drawer
// and the byte-write port toward the memory arbiter.

interface blit_pix_if;
  logic signed [15:0] x;
  logic signed [15:0] y;
  logic               write;
  logic [7:0]         color;
  logic               stall;

  modport master (output x, output y, output write, output color, input stall);
  modport slave  (input x, input y, input write, input color, output stall);
endinterface

interface blit_mem_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready;

  modport master (output mem_valid, output mem_addr, output mem_wdata, input mem_ready);
  modport slave  (input mem_valid, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/blit_pixel_writer.sv
// Pixel stream consumer: clip (when BLIT_CLIP_EN is defined), address generation,
// credit-controlled FIFO and valid/ready byte-write issue to memory.

module blit_pixel_writer #(
  parameter int DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  blit_pix_if.slave          pix,
  blit_mem_if.master         mem,
  input  logic [31:0]        fb_base,
  input  logic [15:0]        fb_stride,
  input  logic signed [15:0] clip_x0,
  input  logic signed [15:0] clip_y0,
  input  logic signed [15:0] clip_x1,
  input  logic signed [15:0] clip_y1,
  output logic               busy,
  output logic [15:0]        pix_count,
  output logic [15:0]        clip_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int UW = CW + 1;

`ifdef BLIT_CLIP_EN
  function automatic logic in_rect(input logic signed [15:0] px, input logic signed [15:0] py,
                                   input logic signed [15:0] x0, input logic signed [15:0] y0,
                                   input logic signed [15:0] x1, input logic signed [15:0] y1);
    return (px >= x0) && (px <= x1) && (py >= y0) && (py <= y1);
  endfunction
`endif

  // Low 32 bits of a product do not depend on operand signedness, so the
  // sign-extended row index can be multiplied by the zero-extended stride.
  function automatic logic [31:0] pix_addr(input logic [31:0] base, input logic [15:0] stride,
                                           input logic signed [15:0] px,
                                           input logic signed [15:0] py);
    logic [31:0] xe;
    logic [31:0] ye;
    logic [31:0] se;
    xe = {{16{px[15]}}, px};
    ye = {{16{py[15]}}, py};
    se = {16'd0, stride};
    return base + (ye * se) + xe;
  endfunction

  logic               stall_w;
  logic               accept_w;
  logic [UW-1:0]      used_w;

  logic               vld_p1_q, vld_p1_d;
  logic               in_p1_q, in_p1_d;
  logic signed [15:0] x_p1_q, y_p1_q;
  logic [7:0]         col_p1_q;

  logic               vld_p2_q, vld_p2_d;
  logic signed [15:0] x_p2_q, y_p2_q;
  logic [7:0]         col_p2_q;
  logic [31:0]        addr_p2;

  logic [31:0]        fa_q [DEPTH];
  logic [7:0]         fd_q [DEPTH];
  logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               push_w, pop_w, empty_w;

  logic [15:0]        pix_q, pix_d;
  logic [15:0]        clip_q, clip_d;

  // Credits count everything already committed downstream, so a full FIFO
  // can never be overrun by pixels still in the two stages.
  assign used_w  = UW'(cnt_q) + UW'(vld_p1_q) + UW'(vld_p2_q);
  assign stall_w = (used_w >= UW'(DEPTH));
  assign addr_p2 = pix_addr(fb_base, fb_stride, x_p2_q, y_p2_q);

  always_comb begin
    accept_w = pix.write && !stall_w;
    vld_p1_d = accept_w;
`ifdef BLIT_CLIP_EN
    in_p1_d  = in_rect(pix.x, pix.y, clip_x0, clip_y0, clip_x1, clip_y1);
`else
    in_p1_d  = 1'b1;
`endif
    vld_p2_d = vld_p1_q && in_p1_q;
    empty_w  = (cnt_q == '0);
    push_w   = vld_p2_q;
    pop_w    = !empty_w && mem.mem_ready;
    wr_d     = push_w ? wr_q + AW'(1) : wr_q;
    rd_d     = pop_w  ? rd_q + AW'(1) : rd_q;
    cnt_d    = cnt_q + CW'(push_w) - CW'(pop_w);
    pix_d    = pix_q + 16'(pop_w);
`ifdef BLIT_CLIP_EN
    clip_d   = clip_q + 16'(vld_p1_q && !in_p1_q);
`else
    clip_d   = '0;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      pix_q    <= '0;
      clip_q   <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      pix_q    <= pix_d;
      clip_q   <= clip_d;
    end
  end

  always_ff @(posedge clock) begin
    // S1: acceptance register, clip verdict captured with the pixel
    if (accept_w) begin
      x_p1_q   <= pix.x;
      y_p1_q   <= pix.y;
      col_p1_q <= pix.color;
      in_p1_q  <= in_p1_d;
    end
    // S2: address formed combinationally from these registers
    if (vld_p1_q) begin
      x_p2_q   <= x_p1_q;
      y_p2_q   <= y_p1_q;
      col_p2_q <= col_p1_q;
    end
    // FIFO write
    if (push_w) begin
      fa_q[wr_q] <= addr_p2;
      fd_q[wr_q] <= col_p2_q;
    end
  end

  // Head is gated by occupancy so the address/data read zero after reset
  // without needing to reset the storage array.
  assign pix.stall     = stall_w;
  assign mem.mem_valid = !empty_w;
  assign mem.mem_addr  = empty_w ? 32'd0 : fa_q[rd_q];
  assign mem.mem_wdata = empty_w ? 8'd0  : fd_q[rd_q];
  assign busy          = vld_p1_q || vld_p2_q || !empty_w;
  assign pix_count     = pix_q;
  assign clip_count    = clip_q;

endmodule
